// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator frequency counter.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int unsigned WIN_DEFAULT = 100;

endpackage

// File: rtl/ro_edge_sync.sv
// Multi-flop synchroniser for an asynchronous oscillator input, followed by
// a one-cycle pulse on each synchronised rising edge.
module ro_edge_sync
  import ro_meas_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_counter_mc.sv
// Multi-channel RO frequency counter: selects one oscillator, counts its rising
// edges over a window of clk cycles and hands the result over valid/ready.
module ro_freq_counter_mc
  import ro_meas_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  osc_in,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic [WIN_W-1:0] win_len,
  input  logic             mode,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic [CH_W-1:0]  result_ch,
  output logic             result_ovf,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [CH_W-1:0] wrap_ch(input logic [CH_W-1:0] c);
    return CH_W'(32'(c) % N_CH);
  endfunction

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return CH_W'((32'(c) + 32'd1) % N_CH);
  endfunction

  // Returns {ovf, count}; the count sticks at its maximum instead of wrapping.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c,
                                             input logic             ovf,
                                             input logic             inc);
    if (!inc)          return {ovf, c};
    if (c == CNT_MAX)  return {1'b1, c};
    return {ovf, c + 1'b1};
  endfunction

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               mode_q, mode_d;
  logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   result_q, result_d;
  logic [CH_W-1:0]    result_ch_q, result_ch_d;
  logic               result_ovf_q, result_ovf_d;
  logic               result_valid_q, result_valid_d;

  logic osc_sel;
  logic edge_pulse;

  // The mux follows the latched channel, so ARM flushes stale samples of the
  // previous channel out of the synchroniser before counting starts.
  assign osc_sel = osc_in[ch_q];

  ro_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (osc_sel),
    .rise (edge_pulse)
  );

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    win_d          = win_q;
    mode_d         = mode_q;
    arm_cnt_d      = arm_cnt_q;
    win_cnt_d      = win_cnt_q;
    cnt_d          = cnt_q;
    ovf_d          = ovf_q;
    result_d       = result_q;
    result_ch_d    = result_ch_q;
    result_ovf_d   = result_ovf_q;
    result_valid_d = result_valid_q;

    case (state_q)
      IDLE: begin
        if (start && (win_len != '0)) begin
          ch_d      = wrap_ch(ch_sel);
          win_d     = win_len;
          mode_d    = mode;
          arm_cnt_d = ARM_LAST;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          state_d   = ARM;
        end
      end
      ARM: begin
        if (arm_cnt_q == '0) begin
          win_cnt_d = win_q;
          state_d   = COUNT;
        end else begin
          arm_cnt_d = arm_cnt_q - 1'b1;
        end
      end
      COUNT: begin
        {ovf_d, cnt_d} = sat_inc(cnt_q, ovf_q, edge_pulse);
        if (win_cnt_q == WIN_W'(1)) begin
          result_d       = cnt_d;
          result_ch_d    = ch_q;
          result_ovf_d   = ovf_d;
          result_valid_d = 1'b1;
          state_d        = DONE;
        end else begin
          win_cnt_d = win_cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (result_valid_q && result_ready) begin
          result_valid_d = 1'b0;
          mode_d         = mode;
          // Scanning continues only if both the latched and the live mode ask for it.
          if ((mode_q == MODE_SCAN) && (mode == MODE_SCAN)) begin
            ch_d      = next_ch(ch_q);
            arm_cnt_d = ARM_LAST;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            state_d   = ARM;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ch_q           <= '0;
      win_q          <= '0;
      mode_q         <= MODE_SINGLE;
      arm_cnt_q      <= '0;
      win_cnt_q      <= '0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      result_q       <= '0;
      result_ch_q    <= '0;
      result_ovf_q   <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      win_q          <= win_d;
      mode_q         <= mode_d;
      arm_cnt_q      <= arm_cnt_d;
      win_cnt_q      <= win_cnt_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      result_q       <= result_d;
      result_ch_q    <= result_ch_d;
      result_ovf_q   <= result_ovf_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign result_ch    = result_ch_q;
  assign result_ovf   = result_ovf_q;
  assign result_valid = result_valid_q;

endmodule
